// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - shift-and-add multiply sequencer driving a shared external adder
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op_a, op_b   request pulse (sampled in IDLE) with multiplicand / multiplier
//   busy, done          busy in RUN and DONE; done is a one-cycle product-valid pulse
//   prod_hi, prod_lo    upper / lower half of the 2*WIDTH product
//   add_a, add_b, add_cin   operands to the external adder (cin tied low)
//   add_sum, add_carry      combinational result from the external adder
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_carry
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        q   <= op_b;
                        m   <= op_a;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    // Shift the (WIDTH+1)-bit sum right by one across {acc, q}:
                    // carry enters acc's MSB, sum's LSB enters q's MSB and the
                    // consumed multiplier bit falls off q's LSB.
                    acc <= {add_carry, add_sum[WIDTH-1:1]};
                    q   <= {add_sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outside RUN the adder only sees acc + 0, so its output is harmless.
    assign add_a   = acc;
    assign add_b   = (state == RUN && q[0]) ? m : '0;
    assign add_cin = 1'b0;
    assign prod_hi = acc;
    assign prod_lo = q;

endmodule
